// File: rtl/bank_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : bank_mem_responder
// Description : Word-addressed, 4-way bank-interleaved memory model answering
//               cache fill/writeback traffic with per-bank busy timing.
// Revision    : 1.0 - initial release
// ============================================================================
module bank_mem_responder #(
  parameter int DEPTH_LOG2 = 15,
  parameter int BANK_BUSY  = 3,
  parameter int RD_LAT     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        createdump,
  input  logic [15:0] addr,
  input  logic [15:0] data_in,
  input  logic        wr,
  input  logic        rd,
  output logic [15:0] data_out,
  output logic        stall,
  output logic [3:0]  busy,
  output logic        err
);

  localparam int         c_DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [1:0] c_BUSY_LOAD = 2'(BANK_BUSY);

  logic                  w_req;
  logic                  w_accept;
  logic [1:0]            w_bank;
  logic [DEPTH_LOG2-1:0] w_word;
  logic                  w_unused;

  logic [1:0]            r_cnt    [4];
  logic [15:0]           r_mem    [c_DEPTH];
  logic [RD_LAT-1:0]     r_rd_vld;
  logic [15:0]           r_rd_dat [RD_LAT];

  assign w_req    = rd | wr;
  assign w_bank   = addr[2:1];
  assign w_word   = addr[DEPTH_LOG2:1];
  assign err      = (rd & wr) | (w_req & addr[0]);
  assign stall    = w_req & ~err & busy[w_bank];
  assign w_accept = w_req & ~err & ~busy[w_bank] & ~rst;

  // Dump request has no effect on state or timing in the synthesizable model.
  assign w_unused = ^{createdump, addr};

  always_comb begin
    busy = 4'b0000;
    for (int b = 0; b < 4; b++) begin
      busy[b] = (r_cnt[b] != 2'd0);
    end
  end

  // Bank occupancy: load on accept, otherwise count down to idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < 4; b++) begin
        r_cnt[b] <= 2'd0;
      end
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (w_accept && (w_bank == 2'(b))) begin
          r_cnt[b] <= c_BUSY_LOAD;
        end else if (r_cnt[b] != 2'd0) begin
          r_cnt[b] <= r_cnt[b] - 2'd1;
        end
      end
    end
  end

  // Storage and read data pipeline carry no reset; storage survives rst.
  always_ff @(posedge clk) begin
    if (w_accept && wr) begin
      r_mem[w_word] <= data_in;
    end
    if (w_accept && rd) begin
      r_rd_dat[0] <= r_mem[w_word];
    end
    for (int i = 1; i < RD_LAT; i++) begin
      r_rd_dat[i] <= r_rd_dat[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_vld <= '0;
    end else begin
      r_rd_vld[0] <= w_accept & rd;
      for (int i = 1; i < RD_LAT; i++) begin
        r_rd_vld[i] <= r_rd_vld[i-1];
      end
    end
  end

  assign data_out = r_rd_vld[RD_LAT-1] ? r_rd_dat[RD_LAT-1] : 16'h0000;

endmodule
`default_nettype wire

// File: tb/tb_bank_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_bank_mem_responder
// Description : Directed scenarios plus random traffic against a cycle model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bank_mem_responder;

  localparam int DEPTH_LOG2 = 15;
  localparam int BANK_BUSY  = 3;
  localparam int RD_LAT     = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        createdump;
  logic [15:0] addr;
  logic [15:0] data_in;
  logic        wr;
  logic        rd;
  logic [15:0] data_out;
  logic        stall;
  logic [3:0]  busy;
  logic        err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  bank_mem_responder #(
    .DEPTH_LOG2(DEPTH_LOG2),
    .BANK_BUSY (BANK_BUSY),
    .RD_LAT    (RD_LAT)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .createdump(createdump),
    .addr      (addr),
    .data_in   (data_in),
    .wr        (wr),
    .rd        (rd),
    .data_out  (data_out),
    .stall     (stall),
    .busy      (busy),
    .err       (err)
  );

  task automatic drive(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d);
    rd = r; wr = w; addr = a; data_in = d;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 16'h0000, 16'h0000);
  endtask

  task automatic to_edge();
    @(posedge clk); #1;
  endtask

  task automatic to_mid();
    @(negedge clk);
  endtask

  task automatic settle(input int n);
    idle();
    repeat (n) to_edge();
  endtask

  task automatic put(input logic [15:0] a, input logic [15:0] d);
    drive(1'b0, 1'b1, a, d);
    to_edge();
    idle();
  endtask

  task automatic test_reset();
    rst = 1'b1; createdump = 1'b0; idle();
    repeat (2) to_edge();
    to_mid();
    n_cmp++; if (busy !== 4'b0000) begin n_bad++; $display("FAIL reset_busy got %b exp 0000", busy); end
    n_cmp++; if (data_out !== 16'h0000) begin n_bad++; $display("FAIL reset_dout got %h exp 0000", data_out); end
    n_cmp++; if (stall !== 1'b0 || err !== 1'b0) begin n_bad++; $display("FAIL reset_flags got stall=%b err=%b exp 0/0", stall, err); end
    to_edge();
    rst = 1'b0;
    // A write presented during reset must not land in storage nor occupy a bank
    put(16'h0100, 16'h1234);
    settle(4);
    rst = 1'b1;
    drive(1'b0, 1'b1, 16'h0100, 16'hDEAD);
    to_edge();
    rst = 1'b0; idle();
    to_mid();
    n_cmp++; if (busy !== 4'b0000) begin n_bad++; $display("FAIL reset_prio_busy got %b exp 0000", busy); end
    to_edge();
    drive(1'b1, 1'b0, 16'h0100, 16'h0000);
    to_mid();
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL reset_prio_stall got %b exp 0", stall); end
    to_edge(); idle(); to_edge();
    to_mid();
    n_cmp++; if (data_out !== 16'h1234) begin n_bad++; $display("FAIL reset_prio_data got %h exp 1234", data_out); end
    to_edge();
  endtask

  task automatic test_write_read();
    settle(4);
    drive(1'b0, 1'b1, 16'h0010, 16'hBEEF);
    to_mid();
    n_cmp++; if (stall !== 1'b0 || err !== 1'b0) begin n_bad++; $display("FAIL wr_accept got stall=%b err=%b exp 0/0", stall, err); end
    to_edge(); idle();
    for (int k = 1; k <= 3; k++) begin
      to_mid();
      n_cmp++; if (busy !== 4'b0001) begin n_bad++; $display("FAIL wr_busy k=%0d got %b exp 0001", k, busy); end
      to_edge();
    end
    drive(1'b1, 1'b0, 16'h0010, 16'h0000);
    for (int k = 0; k <= 3; k++) begin
      logic [15:0] e;
      e = (k == 2) ? 16'hBEEF : 16'h0000;
      to_mid();
      if (k == 0) begin
        n_cmp++; if (stall !== 1'b0 || busy !== 4'b0000) begin n_bad++; $display("FAIL rd_accept got stall=%b busy=%b exp 0/0000", stall, busy); end
      end
      n_cmp++; if (data_out !== e) begin n_bad++; $display("FAIL rd_data k=%0d got %h exp %h", k, data_out, e); end
      to_edge(); idle();
    end
  endtask

  task automatic test_line_stream();
    logic [15:0] vals [4];
    logic [3:0]  ebusy [7];
    vals  = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    ebusy = '{4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1110, 4'b1100, 4'b1000};
    settle(4);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 16'h1230 + 16'(2*i), vals[i]);
      to_edge();
    end
    settle(4);
    for (int i = 0; i < 7; i++) begin
      logic [15:0] e;
      if (i < 4) drive(1'b1, 1'b0, 16'h1230 + 16'(2*i), 16'h0000);
      else       idle();
      e = (i >= 2 && i <= 5) ? vals[i-2] : 16'h0000;
      to_mid();
      if (i < 4) begin
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL stream_stall i=%0d got %b exp 0", i, stall); end
      end
      n_cmp++; if (busy !== ebusy[i]) begin n_bad++; $display("FAIL stream_busy i=%0d got %b exp %b", i, busy, ebusy[i]); end
      n_cmp++; if (data_out !== e) begin n_bad++; $display("FAIL stream_data i=%0d got %h exp %h", i, data_out, e); end
      to_edge();
    end
  endtask

  task automatic test_bank_conflict();
    settle(4);
    put(16'h0008, 16'h8888);
    settle(4);
    drive(1'b0, 1'b1, 16'h0000, 16'h0C0C);
    to_mid();
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL conf_wr_stall got %b exp 0", stall); end
    to_edge();
    drive(1'b1, 1'b0, 16'h0008, 16'h0000);
    for (int k = 1; k <= 3; k++) begin
      to_mid();
      n_cmp++; if (stall !== 1'b1 || busy !== 4'b0001) begin n_bad++; $display("FAIL conf_stall k=%0d got stall=%b busy=%b exp 1/0001", k, stall, busy); end
      n_cmp++; if (data_out !== 16'h0000) begin n_bad++; $display("FAIL conf_dout k=%0d got %h exp 0000", k, data_out); end
      to_edge();
    end
    to_mid();
    n_cmp++; if (stall !== 1'b0 || busy !== 4'b0000) begin n_bad++; $display("FAIL conf_accept got stall=%b busy=%b exp 0/0000", stall, busy); end
    to_edge(); idle();
    for (int k = 5; k <= 7; k++) begin
      logic [15:0] e;
      e = (k == 6) ? 16'h8888 : 16'h0000;
      to_mid();
      n_cmp++; if (data_out !== e) begin n_bad++; $display("FAIL conf_data k=%0d got %h exp %h", k, data_out, e); end
      to_edge();
    end
    drive(1'b1, 1'b0, 16'h0000, 16'h0000);
    to_mid();
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL conf_rd0_stall got %b exp 0", stall); end
    to_edge(); idle(); to_edge();
    to_mid();
    n_cmp++; if (data_out !== 16'h0C0C) begin n_bad++; $display("FAIL conf_rd0_data got %h exp 0c0c", data_out); end
    to_edge();
  endtask

  task automatic test_errors();
    settle(4);
    drive(1'b0, 1'b1, 16'h0004, 16'h0404);
    to_mid();
    n_cmp++; if (stall !== 1'b0 || err !== 1'b0) begin n_bad++; $display("FAIL err_setup got stall=%b err=%b exp 0/0", stall, err); end
    to_edge();
    drive(1'b1, 1'b1, 16'h0004, 16'hFFFF);
    to_mid();
    n_cmp++; if (err !== 1'b1 || stall !== 1'b0) begin n_bad++; $display("FAIL err_rdwr got err=%b stall=%b exp 1/0", err, stall); end
    n_cmp++; if (busy !== 4'b0100) begin n_bad++; $display("FAIL err_rdwr_busy got %b exp 0100", busy); end
    to_edge();
    drive(1'b1, 1'b0, 16'h0003, 16'h0000);
    to_mid();
    n_cmp++; if (err !== 1'b1 || stall !== 1'b0) begin n_bad++; $display("FAIL err_odd_rd got err=%b stall=%b exp 1/0", err, stall); end
    to_edge();
    drive(1'b0, 1'b1, 16'h0007, 16'h7777);
    to_mid();
    n_cmp++; if (err !== 1'b1 || busy !== 4'b0100) begin n_bad++; $display("FAIL err_odd_wr got err=%b busy=%b exp 1/0100", err, busy); end
    to_edge(); idle();
    for (int k = 4; k <= 5; k++) begin
      to_mid();
      n_cmp++; if (busy !== 4'b0000 || data_out !== 16'h0000) begin n_bad++; $display("FAIL err_no_effect k=%0d got busy=%b dout=%h exp 0000/0000", k, busy, data_out); end
      to_edge();
    end
    drive(1'b1, 1'b0, 16'h0004, 16'h0000);
    to_edge(); idle(); to_edge();
    to_mid();
    n_cmp++; if (data_out !== 16'h0404) begin n_bad++; $display("FAIL err_readback got %h exp 0404", data_out); end
    to_edge();
  endtask

  task automatic test_reset_mid_read();
    settle(4);
    put(16'h0020, 16'h2020);
    settle(4);
    drive(1'b1, 1'b0, 16'h0020, 16'h0000);
    to_mid();
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL rmr_accept got stall=%b exp 0", stall); end
    to_edge();
    rst = 1'b1;
    drive(1'b0, 1'b1, 16'h0020, 16'hDEAD);
    to_mid();
    n_cmp++; if (busy !== 4'b0001) begin n_bad++; $display("FAIL rmr_busy_pre got %b exp 0001", busy); end
    to_edge();
    rst = 1'b0;
    drive(1'b1, 1'b0, 16'h0020, 16'h0000);
    to_mid();
    n_cmp++; if (data_out !== 16'h0000 || busy !== 4'b0000) begin n_bad++; $display("FAIL rmr_flush got dout=%h busy=%b exp 0000/0000", data_out, busy); end
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL rmr_reread_stall got %b exp 0", stall); end
    to_edge(); idle();
    for (int k = 1; k <= 3; k++) begin
      logic [15:0] e;
      e = (k == 2) ? 16'h2020 : 16'h0000;
      to_mid();
      n_cmp++; if (data_out !== e) begin n_bad++; $display("FAIL rmr_reread k=%0d got %h exp %h", k, data_out, e); end
      to_edge();
    end
  endtask

  task automatic test_wrap();
    logic [15:0] wa [2];
    logic [15:0] wd [2];
    wa = '{16'h0002, 16'h0004};
    wd = '{16'hA5A5, 16'h5A5A};
    for (int n = 0; n < 2; n++) begin
      int  t;
      logic acc;
      settle(4);
      put(wa[n], wd[n]);
      drive(1'b1, 1'b0, wa[n], 16'h0000);
      acc = 1'b0;
      for (t = 0; t < 8; t++) begin
        to_mid();
        if (stall === 1'b0 && err === 1'b0) begin
          acc = 1'b1;
          to_edge();
          break;
        end
        to_edge();
      end
      n_cmp++; if (acc !== 1'b1 || t != BANK_BUSY) begin n_bad++; $display("FAIL wrap_stall_len n=%0d got acc=%b stalls=%0d exp 1/%0d", n, acc, t, BANK_BUSY); end
      idle();
      to_edge();
      to_mid();
      n_cmp++; if (data_out !== wd[n]) begin n_bad++; $display("FAIL wrap_data n=%0d got %h exp %h", n, data_out, wd[n]); end
      to_edge();
    end
  endtask

  task automatic test_random();
    logic [15:0] mdl   [int];
    logic [15:0] exp_q [int];
    int          free_at [4];
    int          c;
    settle(5);
    c = 0;
    for (int b = 0; b < 4; b++) free_at[b] = 0;
    for (int i = 0; i < 64; i++) begin
      logic [15:0] a, d;
      int          bk;
      a  = 16'h4000 + 16'(2*i);
      d  = 16'($urandom);
      bk = (int'(a) / 2) % 4;
      drive(1'b0, 1'b1, a, d);
      to_mid();
      n_cmp++; if (stall !== 1'b0 || err !== 1'b0) begin n_bad++; $display("FAIL rand_preload i=%0d got stall=%b err=%b exp 0/0", i, stall, err); end
      mdl[(int'(a) / 2) % (1 << DEPTH_LOG2)] = d;
      free_at[bk] = c + BANK_BUSY + 1;
      to_edge(); c++;
    end
    for (int i = 0; i < 400; i++) begin
      logic [15:0] a, d, e_dout;
      logic        r, w, e_err, e_stall;
      logic [3:0]  e_busy;
      int          op, bk, wd;
      op = $urandom_range(0, 9);
      r  = (op <= 3) || (op == 7);
      w  = (op >= 4) && (op <= 7);
      a  = 16'h4000 + 16'(2 * $urandom_range(0, 63));
      if ($urandom_range(0, 15) == 0) a = a + 16'd1;
      d  = 16'($urandom);
      createdump = ($urandom_range(0, 7) == 0);
      bk = (int'(a) / 2) % 4;
      wd = (int'(a) / 2) % (1 << DEPTH_LOG2);
      for (int b = 0; b < 4; b++) e_busy[b] = (c < free_at[b]);
      e_err   = (r && w) || ((r || w) && (int'(a) % 2 == 1));
      e_stall = (r || w) && !e_err && e_busy[bk];
      e_dout  = exp_q.exists(c) ? exp_q[c] : 16'h0000;
      drive(r, w, a, d);
      to_mid();
      n_cmp++; if (err !== e_err) begin n_bad++; $display("FAIL rand_err c=%0d got %b exp %b", c, err, e_err); end
      n_cmp++; if (stall !== e_stall) begin n_bad++; $display("FAIL rand_stall c=%0d got %b exp %b", c, stall, e_stall); end
      n_cmp++; if (busy !== e_busy) begin n_bad++; $display("FAIL rand_busy c=%0d got %b exp %b", c, busy, e_busy); end
      n_cmp++; if (data_out !== e_dout) begin n_bad++; $display("FAIL rand_dout c=%0d got %h exp %h", c, data_out, e_dout); end
      if ((r || w) && !e_err && !e_stall) begin
        free_at[bk] = c + BANK_BUSY + 1;
        if (w) mdl[wd] = d;
        if (r) exp_q[c + RD_LAT] = mdl[wd];
      end
      to_edge(); c++;
    end
    idle(); createdump = 1'b0;
    for (int k = 0; k <= RD_LAT; k++) begin
      logic [15:0] e_dout;
      e_dout = exp_q.exists(c) ? exp_q[c] : 16'h0000;
      to_mid();
      n_cmp++; if (data_out !== e_dout) begin n_bad++; $display("FAIL rand_drain c=%0d got %h exp %h", c, data_out, e_dout); end
      to_edge(); c++;
    end
  endtask

  initial begin
    rst = 1'b1;
    createdump = 1'b0;
    idle();
    test_reset();
    test_write_read();
    test_line_stream();
    test_bank_conflict();
    test_errors();
    test_reset_mid_read();
    test_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog_timeout got running exp finished");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
